// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage
// Description : ID/EX pipeline register for the five-stage RV32I pipeline,
//               with integrated load-use hazard detection. Captures the
//               decoder control bundle and ID operands every cycle, stalls
//               PC and IF/ID on a load-use dependency and inserts bubbles
//               into EX, both for load-use hazards and on branch/jump flush.
//
// Parameters  : LOAD_BUBBLES  bubbles inserted per load-use hazard (1..7)
// Optional    : ID_EX_PERF_CNT_EN  adds saturating bubble/flush counters
//
// Ports       : clk          rising-edge clock
//               reset        asynchronous reset, active low
//               flush_i      EX-stage redirect, squashes the ID instruction
//               Ctrl_i       16-bit decoder control bundle
//               PC_i, Rs1_data_i, Rs2_data_i, Imm_i     32-bit ID operands
//               Rs1_addr_i, Rs2_addr_i, Rd_addr_i       register indices
//               Funct3_i     funct3 field
//               *_o          registered copies of the above
//               stall_o      combinational hold for PC and IF/ID
//               bubble_cnt_o, flush_cnt_o   (only with ID_EX_PERF_CNT_EN)
//
// Revision    : 1.0  initial release
// ============================================================================
module id_ex_stage #(
    parameter int LOAD_BUBBLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush_i,
    input  logic [15:0] Ctrl_i,
    input  logic [31:0] PC_i,
    input  logic [31:0] Rs1_data_i,
    input  logic [31:0] Rs2_data_i,
    input  logic [31:0] Imm_i,
    input  logic [4:0]  Rs1_addr_i,
    input  logic [4:0]  Rs2_addr_i,
    input  logic [4:0]  Rd_addr_i,
    input  logic [2:0]  Funct3_i,
    output logic [15:0] Ctrl_o,
    output logic [31:0] PC_o,
    output logic [31:0] Rs1_data_o,
    output logic [31:0] Rs2_data_o,
    output logic [31:0] Imm_o,
    output logic [4:0]  Rs1_addr_o,
    output logic [4:0]  Rs2_addr_o,
    output logic [4:0]  Rd_addr_o,
    output logic [2:0]  Funct3_o,
    output logic        stall_o
`ifdef ID_EX_PERF_CNT_EN
    ,
    output logic [15:0] bubble_cnt_o,
    output logic [15:0] flush_cnt_o
`endif
);

    localparam logic [0:0] S_RUN   = 1'b0;
    localparam logic [0:0] S_STALL = 1'b1;

    // Remaining bubbles after the one inserted on the hazard edge itself.
    localparam logic [2:0] C_STALL_CNT  = 3'(LOAD_BUBBLES - 1);
    localparam logic       C_MULTI_BUBL = (LOAD_BUBBLES > 1);

    logic [0:0]  state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;

    logic [15:0] ctrl_q, ctrl_d;
    logic [31:0] pc_q, rs1_data_q, rs2_data_q, imm_q;
    logic [4:0]  rs1_addr_q, rs2_addr_q, rd_addr_q, rd_addr_d;
    logic [2:0]  funct3_q;

    logic        valid, use_rs1, use_rs2, hazard, bubble, stall;

    // ------------------------------------------------------------------
    // Source-use decode and load-use detection
    // ------------------------------------------------------------------
    always_comb begin
        valid   = (Ctrl_i != 16'h0000);
        // JAL field 2'b10 marks JALR, which reads rs1 even with a PC source.
        use_rs1 = valid & ((Ctrl_i[13:12] == 2'b00) | (Ctrl_i[15:14] == 2'b10));
        // Stores read rs2 as data even when ALU operand b is the immediate.
        use_rs2 = valid & ((Ctrl_i[11:10] == 2'b00) | Ctrl_i[6]);
        hazard  = ctrl_q[7] & (rd_addr_q != 5'd0) &
                  ((use_rs1 & (Rs1_addr_i == rd_addr_q)) |
                   (use_rs2 & (Rs2_addr_i == rd_addr_q)));
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_RUN;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (flush_i) begin
            state_d = S_RUN;
            cnt_d   = 3'd0;
        end else if (state_q == S_STALL) begin
            if (cnt_q == 3'd1) begin
                state_d = S_RUN;
                cnt_d   = 3'd0;
            end else begin
                cnt_d = cnt_q - 3'd1;
            end
        end else if (hazard && C_MULTI_BUBL) begin
            state_d = S_STALL;
            cnt_d   = C_STALL_CNT;
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        bubble = 1'b0;
        stall  = 1'b0;
        if (flush_i) begin
            bubble = 1'b1;
        end else if (state_q == S_STALL) begin
            bubble = 1'b1;
            stall  = 1'b1;
        end else if (hazard) begin
            bubble = 1'b1;
            stall  = 1'b1;
        end
    end

    assign stall_o = stall;

    // ------------------------------------------------------------------
    // Pipeline register: a bubble clears only control and destination,
    // operand fields keep flowing so they need no extra muxing.
    // ------------------------------------------------------------------
    always_comb begin
        ctrl_d    = bubble ? 16'h0000 : Ctrl_i;
        rd_addr_d = bubble ? 5'd0     : Rd_addr_i;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_q     <= 16'h0000;
            pc_q       <= 32'h0;
            rs1_data_q <= 32'h0;
            rs2_data_q <= 32'h0;
            imm_q      <= 32'h0;
            rs1_addr_q <= 5'd0;
            rs2_addr_q <= 5'd0;
            rd_addr_q  <= 5'd0;
            funct3_q   <= 3'd0;
        end else begin
            ctrl_q     <= ctrl_d;
            pc_q       <= PC_i;
            rs1_data_q <= Rs1_data_i;
            rs2_data_q <= Rs2_data_i;
            imm_q      <= Imm_i;
            rs1_addr_q <= Rs1_addr_i;
            rs2_addr_q <= Rs2_addr_i;
            rd_addr_q  <= rd_addr_d;
            funct3_q   <= Funct3_i;
        end
    end

    assign Ctrl_o     = ctrl_q;
    assign PC_o       = pc_q;
    assign Rs1_data_o = rs1_data_q;
    assign Rs2_data_o = rs2_data_q;
    assign Imm_o      = imm_q;
    assign Rs1_addr_o = rs1_addr_q;
    assign Rs2_addr_o = rs2_addr_q;
    assign Rd_addr_o  = rd_addr_q;
    assign Funct3_o   = funct3_q;

`ifdef ID_EX_PERF_CNT_EN
    // ------------------------------------------------------------------
    // Saturating performance counters. A flush bubble is counted only as
    // a flush, never as a load-use bubble.
    // ------------------------------------------------------------------
    logic [15:0] bubble_cnt_q, bubble_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        if (bubble && !flush_i && (bubble_cnt_q != 16'hFFFF)) begin
            bubble_cnt_d = bubble_cnt_q + 16'd1;
        end
        if (flush_i && (flush_cnt_q != 16'hFFFF)) begin
            flush_cnt_d = flush_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bubble_cnt_q <= 16'h0000;
            flush_cnt_q  <= 16'h0000;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign bubble_cnt_o = bubble_cnt_q;
    assign flush_cnt_o  = flush_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_ex_stage
// Description : Directed bench for id_ex_stage. Two instances share one
//               stimulus stream: one with LOAD_BUBBLES=1, one with
//               LOAD_BUBBLES=3. Expected values are hand-computed.
// Revision    : 1.0  initial release
// ============================================================================
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush_i;
    logic [15:0] Ctrl_i;
    logic [31:0] PC_i, Rs1_data_i, Rs2_data_i, Imm_i;
    logic [4:0]  Rs1_addr_i, Rs2_addr_i, Rd_addr_i;
    logic [2:0]  Funct3_i;

    logic [15:0] ctrl1, ctrl3;
    logic [31:0] pc1, pc3, r1d1, r1d3, r2d1, r2d3, imm1, imm3;
    logic [4:0]  ra1_1, ra1_3, ra2_1, ra2_3, rd1, rd3;
    logic [2:0]  f3_1, f3_3;
    logic        stall1, stall3;
`ifdef ID_EX_PERF_CNT_EN
    logic [15:0] bcnt1, bcnt3, fcnt1, fcnt3;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.LOAD_BUBBLES(1)) dut1 (
        .clk(clk), .reset(reset), .flush_i(flush_i), .Ctrl_i(Ctrl_i),
        .PC_i(PC_i), .Rs1_data_i(Rs1_data_i), .Rs2_data_i(Rs2_data_i),
        .Imm_i(Imm_i), .Rs1_addr_i(Rs1_addr_i), .Rs2_addr_i(Rs2_addr_i),
        .Rd_addr_i(Rd_addr_i), .Funct3_i(Funct3_i),
        .Ctrl_o(ctrl1), .PC_o(pc1), .Rs1_data_o(r1d1), .Rs2_data_o(r2d1),
        .Imm_o(imm1), .Rs1_addr_o(ra1_1), .Rs2_addr_o(ra2_1),
        .Rd_addr_o(rd1), .Funct3_o(f3_1), .stall_o(stall1)
`ifdef ID_EX_PERF_CNT_EN
        , .bubble_cnt_o(bcnt1), .flush_cnt_o(fcnt1)
`endif
    );

    id_ex_stage #(.LOAD_BUBBLES(3)) dut3 (
        .clk(clk), .reset(reset), .flush_i(flush_i), .Ctrl_i(Ctrl_i),
        .PC_i(PC_i), .Rs1_data_i(Rs1_data_i), .Rs2_data_i(Rs2_data_i),
        .Imm_i(Imm_i), .Rs1_addr_i(Rs1_addr_i), .Rs2_addr_i(Rs2_addr_i),
        .Rd_addr_i(Rd_addr_i), .Funct3_i(Funct3_i),
        .Ctrl_o(ctrl3), .PC_o(pc3), .Rs1_data_o(r1d3), .Rs2_data_o(r2d3),
        .Imm_o(imm3), .Rs1_addr_o(ra1_3), .Rs2_addr_o(ra2_3),
        .Rd_addr_o(rd3), .Funct3_o(f3_3), .stall_o(stall3)
`ifdef ID_EX_PERF_CNT_EN
        , .bubble_cnt_o(bcnt3), .flush_cnt_o(fcnt3)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge; return 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] c, input logic [31:0] pc,
                         input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd);
        Ctrl_i     = c;
        PC_i       = pc;
        Rs1_addr_i = rs1;
        Rs2_addr_i = rs2;
        Rd_addr_i  = rd;
        Rs1_data_i = {16'hA000, 11'd0, rs1};
        Rs2_data_i = {16'hB000, 11'd0, rs2};
        Imm_i      = pc ^ 32'h5A5A_0000;
        Funct3_i   = rd[2:0];
    endtask

    initial begin
        reset   = 1'b0;
        flush_i = 1'b0;
        drive(16'h0000, 32'h0, 5'd0, 5'd0, 5'd0);
        tick();
        tick();
        check("rst_ctrl1", {16'h0, ctrl1}, 32'h0);
        check("rst_ctrl3", {16'h0, ctrl3}, 32'h0);
        check("rst_pc1", pc1, 32'h0);
        check("rst_stall1", {31'h0, stall1}, 32'h0);
        check("rst_stall3", {31'h0, stall3}, 32'h0);

        // Release reset away from the edge.
        #3 reset = 1'b1;
        tick();

        // Plain R-type flow.
        drive(16'h0102, 32'h100, 5'd1, 5'd2, 5'd3);
        #1;
        check("rtype_stall1", {31'h0, stall1}, 32'h0);
        tick();
        check("rtype_ctrl1", {16'h0, ctrl1}, 32'h0102);
        check("rtype_pc1", pc1, 32'h100);
        check("rtype_rd3", {27'h0, rd3}, 32'd3);
        check("rtype_r2d1", r2d1, 32'hB000_0002);
        check("rtype_imm3", imm3, 32'h5A5A_0100);
        check("rtype_f3_1", {29'h0, f3_1}, 32'd3);

        // Load x5.
        drive(16'h0780, 32'h104, 5'd1, 5'd0, 5'd5);
        #1;
        check("ld_nostall3", {31'h0, stall3}, 32'h0);
        tick();
        check("ld_ctrl3", {16'h0, ctrl3}, 32'h0780);
        check("ld_rd1", {27'h0, rd1}, 32'd5);

        // Dependent R-type reads x5 as rs2.
        drive(16'h0102, 32'h108, 5'd6, 5'd5, 5'd8);
        #1;
        check("hz_stall1", {31'h0, stall1}, 32'h1);
        check("hz_stall3", {31'h0, stall3}, 32'h1);
        tick();
        check("hz_bub_ctrl1", {16'h0, ctrl1}, 32'h0);
        check("hz_bub_rd1", {27'h0, rd1}, 32'h0);
        check("hz_bub_ctrl3", {16'h0, ctrl3}, 32'h0);
        check("hz_bub_pc3", pc3, 32'h108);
        check("hz_bub_ra2_1", {27'h0, ra2_1}, 32'd5);
        // Second cycle: LB=1 releases, LB=3 still stalled.
        #1;
        check("hz2_stall1", {31'h0, stall1}, 32'h0);
        check("hz2_stall3", {31'h0, stall3}, 32'h1);
        tick();
        check("hz2_ctrl1", {16'h0, ctrl1}, 32'h0102);
        check("hz2_rd1", {27'h0, rd1}, 32'd8);
        check("hz2_ctrl3", {16'h0, ctrl3}, 32'h0);
        #1;
        check("hz3_stall1", {31'h0, stall1}, 32'h0);
        check("hz3_stall3", {31'h0, stall3}, 32'h1);
        tick();
        check("hz3_ctrl3", {16'h0, ctrl3}, 32'h0);
        #1;
        check("hz4_stall3", {31'h0, stall3}, 32'h0);
        tick();
        check("hz4_ctrl3", {16'h0, ctrl3}, 32'h0102);
        check("hz4_rd3", {27'h0, rd3}, 32'd8);

        // Load to x0 followed by user of x0: no stall.
        drive(16'h0780, 32'h10C, 5'd1, 5'd0, 5'd0);
        tick();
        drive(16'h0102, 32'h110, 5'd0, 5'd0, 5'd9);
        #1;
        check("x0_stall1", {31'h0, stall1}, 32'h0);
        check("x0_stall3", {31'h0, stall3}, 32'h0);
        tick();

        // Load x7, then all-zero control and LUI naming x7: no stall.
        drive(16'h0780, 32'h114, 5'd1, 5'd0, 5'd7);
        tick();
        drive(16'h0000, 32'h118, 5'd7, 5'd7, 5'd0);
        #1;
        check("nop_stall3", {31'h0, stall3}, 32'h0);
        drive(16'h2500, 32'h118, 5'd7, 5'd9, 5'd10);
        #1;
        check("lui_stall1", {31'h0, stall1}, 32'h0);
        check("lui_stall3", {31'h0, stall3}, 32'h0);
        tick();
        check("lui_ctrl3", {16'h0, ctrl3}, 32'h2500);

        // Flush during the second cycle of a 3-bubble stall.
        drive(16'h0780, 32'h11C, 5'd1, 5'd0, 5'd5);
        tick();
        drive(16'h0102, 32'h120, 5'd5, 5'd2, 5'd11);
        #1;
        check("fl_hz_stall3", {31'h0, stall3}, 32'h1);
        tick();
        flush_i = 1'b1;
        #1;
        check("fl_stall3", {31'h0, stall3}, 32'h0);
        check("fl_stall1", {31'h0, stall1}, 32'h0);
        tick();
        flush_i = 1'b0;
        check("fl_ctrl3", {16'h0, ctrl3}, 32'h0);
        check("fl_rd3", {27'h0, rd3}, 32'h0);
        check("fl_pc3", pc3, 32'h120);
        #1;
        check("fl_run_stall3", {31'h0, stall3}, 32'h0);
`ifdef ID_EX_PERF_CNT_EN
        check("perf_bcnt1", {16'h0, bcnt1}, 32'd2);
        check("perf_bcnt3", {16'h0, bcnt3}, 32'd4);
        check("perf_fcnt1", {16'h0, fcnt1}, 32'd1);
        check("perf_fcnt3", {16'h0, fcnt3}, 32'd1);
`endif
        tick();
        check("fl_after_ctrl3", {16'h0, ctrl3}, 32'h0102);

        // Reset asserted mid-stall.
        drive(16'h0780, 32'h124, 5'd1, 5'd0, 5'd5);
        tick();
        drive(16'h0102, 32'h128, 5'd6, 5'd5, 5'd12);
        tick();
        check("rs_pre_stall3", {31'h0, stall3}, 32'h1);
        reset = 1'b0;
        #1;
        check("rs_stall3", {31'h0, stall3}, 32'h0);
        check("rs_ctrl3", {16'h0, ctrl3}, 32'h0);
        check("rs_pc3", pc3, 32'h0);
        check("rs_rd3", {27'h0, rd3}, 32'h0);
`ifdef ID_EX_PERF_CNT_EN
        check("rs_bcnt3", {16'h0, bcnt3}, 32'd0);
`endif
        #2 reset = 1'b1;
        #1;
        check("rs_rel_stall3", {31'h0, stall3}, 32'h0);
        tick();
        check("rs_cap_ctrl3", {16'h0, ctrl3}, 32'h0102);
        check("rs_cap_rd3", {27'h0, rd3}, 32'd12);
        check("rs_cap_pc1", pc1, 32'h128);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog so the bench always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register with integrated load-use hazard detection for the five-stage RV32I pipeline. It sits directly downstream of the instruction decoder and captures the decoder's 16-bit control bundle plus the ID-stage operands each cycle. It stalls PC and IF/ID for a load-use dependency and inserts bubbles into EX. Bubbles are also inserted on a flush from branch/jump resolution.

## Interface

Parameters:
- `LOAD_BUBBLES`, default 1: number of bubbles inserted per load-use hazard. Legal range 1–7 (covers multi-cycle data memory).

Ports:
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserted when 0).
- `flush_i`  in  1  EX-stage redirect (taken branch, JAL, JALR); squashes the ID instruction.
- `Ctrl_i`  in  16  decoder bundle:
  - [15:14] JAL, [13:12] ALU_Src_a, [11:10] ALU_Src_b
  - [9] Mem_to_Reg, [8] Reg_Write, [7] Mem_Read, [6] Mem_Write
  - [5] Branch, [4] Branch_n, [3:0] ALU_OP
- `PC_i`, `Rs1_data_i`, `Rs2_data_i`, `Imm_i`  in  32 each  ID operands.
- `Rs1_addr_i`, `Rs2_addr_i`, `Rd_addr_i`  in  5 each  register indices.
- `Funct3_i`  in  3  funct3 field.
- `Ctrl_o`  out  16  registered control, same bit layout as `Ctrl_i`.
- `PC_o`, `Rs1_data_o`, `Rs2_data_o`, `Imm_o`  out  32 each  registered operands.
- `Rs1_addr_o`, `Rs2_addr_o`, `Rd_addr_o`  out  5 each; `Funct3_o`  out  3.
- `stall_o`  out  1  combinational; holds PC and IF/ID when 1.

## Operation

- Source-use decode, computed from `Ctrl_i` only, with `valid = (Ctrl_i != 0)`:
  - `use_rs1 = valid & (ALU_Src_a==2'b00 | JAL==2'b10)`
  - `use_rs2 = valid & (ALU_Src_b==2'b00 | Mem_Write)`
- Hazard: `Ctrl_o[7]` (EX is a load) & `Rd_addr_o != 0` & ((`use_rs1` & `Rs1_addr_i==Rd_addr_o`) | (`use_rs2` & `Rs2_addr_i==Rd_addr_o`)).
- Bubble: `Ctrl_o` and `Rd_addr_o` load 0. All other output fields load their inputs as normal.
- FSM states are RUN and STALL, with a 3-bit counter `cnt`.
  - RUN, no hazard, no flush: all fields capture their inputs; `stall_o=0`.
  - RUN, hazard, no flush: `stall_o=1`; a bubble enters at the edge. If `LOAD_BUBBLES>1`, go to STALL with `cnt=LOAD_BUBBLES-1`; otherwise stay in RUN.
  - STALL: `stall_o=1` and a bubble is inserted each edge; `cnt` decrements. When `cnt==1` at the edge, go to RUN with `cnt=0`.
  - `flush_i=1` in any state: bubble, `stall_o=0`, next state RUN, `cnt=0`. Flush has priority over hazard and STALL.
- An all-zero `Ctrl_i` (NOP or illegal) never triggers a hazard.
- x0 as destination never triggers a hazard.

## Timing

- Single-cycle latency: inputs at edge N appear on outputs after edge N.
- `stall_o` is combinational from the current inputs and state, valid in the same cycle.
- Reset value of every output register is 0. The FSM resets to RUN with `cnt=0`; `stall_o=0` during reset.
- Reset asserted mid-stall aborts immediately. The first edge after release behaves as RUN.
- Under continuous hazards, each new hazard is evaluated only in RUN. In STALL, `Ctrl_o` holds a bubble, so no re-detection occurs.

## Configuration

- `ID_EX_PERF_CNT_EN`: when defined, adds ports `bubble_cnt_o` (out, 16) and `flush_cnt_o` (out, 16).
  - These are saturating counters (stick at 16'hFFFF), reset to 0.
  - `bubble_cnt_o` increments on each hazard- or stall-induced bubble edge.
  - `flush_cnt_o` increments on each edge with `flush_i=1`.
  - A flush cycle counts only in `flush_cnt_o`.
- Without the macro, the ports and counters do not exist and behaviour is otherwise identical.

## Test plan

- Plain R-type flow: `Ctrl_i=16'h0102`, `PC_i=32'h100`, no hazard -> after one edge `Ctrl_o=16'h0102`, `PC_o=32'h100`, `stall_o=0`.
- Load-use hazard:
  - Setup: EX holds a load (`Ctrl_o=16'h0780`, `Rd_addr_o=5`); ID holds R-type with `Rs2_addr_i=5`.
  - Required: `stall_o=1` and next `Ctrl_o=0`, `Rd_addr_o=0`.
  - Next cycle: `stall_o=0` with `LOAD_BUBBLES=1`.
- `LOAD_BUBBLES=3` with the same hazard -> `stall_o=1` for exactly 3 cycles and 3 consecutive bubbles, then the dependent instruction is captured.
- Negative hazard cases:
  - Load to x0 followed by a user of x0 -> no stall.
  - Load `Rd=7` followed by LUI (`Ctrl_i=16'h2500`, `Rs1_addr_i=7`) -> no stall, since rs1 is unused.
- Flush priority: `flush_i=1` during the second cycle of a 3-bubble stall -> `stall_o=0` that cycle, bubble captured, FSM back to RUN. With `ID_EX_PERF_CNT_EN`, `bubble_cnt_o=1`, `flush_cnt_o=1`.
- Reset mid-stall: assert `reset=0` in STALL -> all outputs 0 and `stall_o=0` immediately. After release, normal capture resumes.
